nibble_serializer: RTL and testbench

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

---
 rtl/nibble_serializer.sv | 111 +++++++++++
 tb/tb_nibble_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serializer.sv
// ============================================================================
// Module   : nibble_serializer
// Function : Parallel word to LSB-first nibble stream, valid/ready both sides.
//            Optional odd-parity output when NIBBLE_SERIALIZER_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serializer #(
    parameter int NIB_W   = 4,
    parameter int NIBBLES = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NIB_W*NIBBLES-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NIB_W-1:0]           out_data,
    output logic [$clog2(NIBBLES)-1:0] out_idx,
    output logic                       out_last,
    output logic [7:0]                 word_cnt
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    ,
    output logic                       out_par
`endif
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_hold;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_wcnt;
    logic               r_rdy_en;

    logic               w_valid;
    logic               w_last_pos;
    logic               w_xfer;
    logic               w_last_xfer;
    logic               w_in_ready;
    logic               w_accept;
    logic [NIB_W-1:0]   w_nib [NIBBLES];

    generate
        for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
            assign w_nib[g] = r_hold[g*NIB_W +: NIB_W];
        end
    endgenerate

    // r_rdy_en keeps in_ready low until the first edge after reset release.
    always_comb begin
        w_valid     = (r_state == SEND);
        w_last_pos  = (r_idx == IDX_W'(NIBBLES - 1));
        w_xfer      = w_valid && out_ready;
        w_last_xfer = w_xfer && w_last_pos;
        w_in_ready  = r_rdy_en && (!w_valid || w_last_xfer);
        w_accept    = in_valid && w_in_ready;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SEND;
            SEND:    if (w_last_xfer && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_accept) begin
                r_hold <= in_data;
                r_idx  <= '0;
            end else if (w_xfer) begin
                r_idx  <= w_last_pos ? '0 : r_idx + IDX_W'(1);
            end
            if (w_last_xfer) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_nib[r_idx] : '0;
    assign out_idx   = w_valid ? r_idx : '0;
    assign out_last  = w_valid && w_last_pos;
    assign word_cnt  = r_wcnt;

`ifdef NIBBLE_SERIALIZER_PARITY_EN
    // Odd parity: set so that nibble plus parity bit hold an odd number of ones.
    assign out_par   = w_valid ? ~(^out_data) : 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serializer.sv
// ============================================================================
// Module   : tb_nibble_serializer
// Function : Self-checking bench for nibble_serializer with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serializer;

    localparam int NIB_W   = 4;
    localparam int NIBBLES = 3;
    localparam int W       = NIB_W * NIBBLES;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data   = '0;
    wire           in_ready;
    wire           out_valid;
    wire           out_last;
    wire [3:0]     out_data;
    wire [1:0]     out_idx;
    wire [7:0]     word_cnt;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    wire           out_par;
`endif

    nibble_serializer #(.NIB_W(NIB_W), .NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .word_cnt  (word_cnt)
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        int         idx;
        bit         last;
    } nib_t;

    int   checks  = 0;
    int   errors  = 0;
    nib_t q[$];
    bit   ready_en = 1'b0;
    int   wcnt    = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    int   log_d[$];
    int   log_c[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit   exp_v, exp_rdy;
        nib_t h;
        @(negedge clk);
        exp_v = (q.size() != 0);
        h     = '{d: 4'h0, idx: 0, last: 1'b0};
        if (exp_v) h = q[0];
        exp_rdy = ready_en && (!exp_v || (out_ready && h.last));
        chk("out_valid", out_valid, exp_v);
        chk("in_ready",  in_ready,  exp_rdy);
        chk("out_data",  out_data,  h.d);
        chk("out_idx",   out_idx,   h.idx);
        chk("out_last",  out_last,  h.last);
        chk("word_cnt",  word_cnt,  wcnt);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        chk("out_par",   out_par,   exp_v ? ~(^h.d) : 1'b0);
`endif
        if (exp_v && out_ready) begin
            log_d.push_back(int'(h.d));
            log_c.push_back(cyc);
            if (h.last) wcnt = (wcnt + 1) % 256;
            void'(q.pop_front());
        end
        if (in_valid && exp_rdy) begin
            acc_cnt++;
            for (int i = 0; i < NIBBLES; i++)
                q.push_back('{d: 4'((in_data >> (NIB_W*i)) & 12'hF), idx: i, last: (i == NIBBLES-1)});
        end
        if (rst_n) ready_en = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_word_cnt",  word_cnt,  8'd0);
        q.delete();
        wcnt     = 0;
        ready_en = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int e1[3];
        int e2[6];
        int e3[3];
        e1 = '{3, 5, 10};
        e2 = '{3, 2, 1, 6, 5, 4};
        e3 = '{0, 15, 0};

        do_reset();

        // Single word
        out_ready = 1'b1;
        log_d.delete(); log_c.delete();
        send(12'hA53);
        repeat (4) cycle();
        chk("single_cnt", log_d.size(), 3);
        for (int i = 0; i < 3 && i < log_d.size(); i++) chk("single_nib", log_d[i], e1[i]);
        chk("single_wcnt", word_cnt, 8'd1);

        // Back-to-back, no bubble
        log_d.delete(); log_c.delete();
        in_valid = 1'b1; in_data = 12'h123;
        cycle();
        in_data = 12'h456;
        repeat (3) cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("b2b_cnt", log_d.size(), 6);
        for (int i = 0; i < 6 && i < log_d.size(); i++) chk("b2b_nib", log_d[i], e2[i]);
        if (log_c.size() == 6) chk("b2b_bubble", log_c[5] - log_c[0], 5);
        chk("b2b_wcnt", word_cnt, 8'd3);

        // Backpressure on idx 1
        send(12'hA53);
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_data", out_data, 4'h5);
            chk("bp_idx",  out_idx,  2'd1);
            chk("bp_rdy",  in_ready, 1'b0);
        end
        out_ready = 1'b1;
        repeat (3) cycle();

        // Reset mid-word
        send(12'hA53);
        cycle();
        do_reset();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_wcnt",  word_cnt,  8'd0);
        out_ready = 1'b1;
        log_d.delete(); log_c.delete();
        send(12'h0F0);
        repeat (4) cycle();
        chk("mid_rst_cnt", log_d.size(), 3);
        for (int i = 0; i < 3 && i < log_d.size(); i++) chk("mid_rst_nib", log_d[i], e3[i]);

        // 256 words, counter wraps to 0
        do_reset();
        out_ready = 1'b1;
        acc_cnt   = 0;
        log_d.delete(); log_c.delete();
        for (int i = 0; i < 1200 && (acc_cnt < 256 || q.size() != 0); i++) begin
            in_valid = (acc_cnt < 256);
            in_data  = W'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("wrap_nibs", log_d.size(), 768);
        chk("wrap_cnt",  word_cnt, 8'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = W'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
